// File: rtl/core_types_pkg.sv
// Shared core types: register file geometry and the write-back bundle
// exchanged between the write-back stage and the register file.
package core_types_pkg;

    localparam int NREGS_C = 32;
    localparam int XLEN_C  = 32;
    localparam int AW_C    = 5;

    typedef logic [AW_C-1:0]   reg_idx_t;
    typedef logic [XLEN_C-1:0] xword_t;

    typedef struct packed {
        logic     WregR;
        reg_idx_t rdR;
        xword_t   WdataR;
        logic     Wreg;
        reg_idx_t rd;
        xword_t   Wdata;
    } write_back_out_t;

endpackage

// File: rtl/reg_file_scoreboard_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an in-flight writer and flags
// decode-stage RAW hazards that the write-back bypass cannot cover.
module scoreboard
    import core_types_pkg::*;
#(
    parameter int NREGS = NREGS_C,
    parameter int AW    = AW_C
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             wb_wreg,
    input  logic [AW-1:0]    wb_rd,
    input  logic             issue_valid,
    input  logic             issue_wreg,
    input  logic [AW-1:0]    issue_rd,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    input  logic             use_rs1,
    input  logic             use_rs2,
    output logic             stall,
    output logic [NREGS-1:0] busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             hazard1;
    logic             hazard2;
    logic             set_en;
    logic             clr_en;

    // A write-back landing this cycle is forwarded, so it never stalls.
    always_comb begin
        hazard1 = use_rs1 && (rs1 != '0) && busy_q[rs1] && !(wb_wreg && (wb_rd == rs1));
        hazard2 = use_rs2 && (rs2 != '0) && busy_q[rs2] && !(wb_wreg && (wb_rd == rs2));
        stall   = hazard1 || hazard2;
    end

    // Clear first, then set: the newly issued writer owns the register.
    always_comb begin
        set_en = issue_valid && issue_wreg && (issue_rd != '0) && !stall;
        clr_en = wb_wreg && (wb_rd != '0);
        busy_d = busy_q;
        if (clr_en) busy_d[wb_rd] = 1'b0;
        if (set_en) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_scoreboard.sv
// Architectural register file with write-through read bypass, plus the
// busy-bit scoreboard that generates the decode stall.
module reg_file_scoreboard
    import core_types_pkg::*;
#(
    parameter int NREGS = NREGS_C,
    parameter int XLEN  = XLEN_C,
    parameter int AW    = AW_C
) (
    input  logic            Clock,
    input  logic            nReset,
    input  write_back_out_t wb_in,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            issue_valid,
    input  logic            issue_Wreg,
    input  logic [AW-1:0]   issue_rd,
    input  logic            use_rs1,
    input  logic            use_rs2,
    output logic            stall,
    output logic [NREGS-1:0] busy_vec
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            unused_wb_fields;

    assign unused_wb_fields = ^{wb_in.WregR, wb_in.rdR, wb_in.WdataR};

    always_comb begin
        for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
        if (wb_in.Wreg && (wb_in.rd != '0)) regs_d[wb_in.rd] = wb_in.Wdata;
        regs_d[0] = '0;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    // Reads are gated by nReset so a bypassed write cannot leak out during reset.
    always_comb begin
        rdata1 = '0;
        if (nReset && (rs1 != '0)) begin
            if (wb_in.Wreg && (wb_in.rd == rs1)) rdata1 = wb_in.Wdata;
            else                                 rdata1 = regs_q[rs1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (nReset && (rs2 != '0)) begin
            if (wb_in.Wreg && (wb_in.rd == rs2)) rdata2 = wb_in.Wdata;
            else                                 rdata2 = regs_q[rs2];
        end
    end

    scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .Clock       (Clock),
        .nReset      (nReset),
        .wb_wreg     (wb_in.Wreg),
        .wb_rd       (wb_in.rd),
        .issue_valid (issue_valid),
        .issue_wreg  (issue_Wreg),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .use_rs1     (use_rs1),
        .use_rs2     (use_rs2),
        .stall       (stall),
        .busy_vec    (busy_vec)
    );

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Self-checking bench for reg_file_scoreboard: directed scenarios followed by
// randomized traffic compared against a behavioural register/busy model.
module tb_reg_file_scoreboard;
    import core_types_pkg::*;

    logic                Clock = 1'b0;
    logic                nReset;
    write_back_out_t     wb_in;
    reg_idx_t            rs1;
    reg_idx_t            rs2;
    xword_t              rdata1;
    xword_t              rdata2;
    logic                issue_valid;
    logic                issue_Wreg;
    reg_idx_t            issue_rd;
    logic                use_rs1;
    logic                use_rs2;
    logic                stall;
    logic [NREGS_C-1:0]  busy_vec;

    xword_t mRegs [NREGS_C];
    bit     mBusy [NREGS_C];
    int     assertCount = 0;
    int     failCount   = 0;

    reg_file_scoreboard dut (
        .Clock       (Clock),
        .nReset      (nReset),
        .wb_in       (wb_in),
        .rs1         (rs1),
        .rs2         (rs2),
        .rdata1      (rdata1),
        .rdata2      (rdata2),
        .issue_valid (issue_valid),
        .issue_Wreg  (issue_Wreg),
        .issue_rd    (issue_rd),
        .use_rs1     (use_rs1),
        .use_rs2     (use_rs2),
        .stall       (stall),
        .busy_vec    (busy_vec)
    );

    always #5 Clock = ~Clock;

    // Decode must never issue a second writer to a register still owned by an older one.
    always @(posedge Clock) begin
        if (nReset && issue_valid && issue_Wreg && (issue_rd != '0) && !stall &&
            busy_vec[issue_rd] && !(wb_in.Wreg && (wb_in.rd == issue_rd)))
            $error("[TB] second writer issued to busy x%0d", issue_rd);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NREGS_C; i++) begin
            mRegs[i] = '0;
            mBusy[i] = 1'b0;
        end
    endtask

    function automatic xword_t modelRead(input reg_idx_t idx);
        if (!nReset || idx == 0) return '0;
        if (wb_in.Wreg && wb_in.rd == idx) return wb_in.Wdata;
        return mRegs[idx];
    endfunction

    function automatic logic modelStall();
        logic h1, h2;
        h1 = use_rs1 && rs1 != 0 && mBusy[rs1] && !(wb_in.Wreg && wb_in.rd == rs1);
        h2 = use_rs2 && rs2 != 0 && mBusy[rs2] && !(wb_in.Wreg && wb_in.rd == rs2);
        return nReset && (h1 || h2);
    endfunction

    function automatic logic [31:0] modelBusyVec();
        logic [31:0] v = '0;
        for (int i = 1; i < NREGS_C; i++) v[i] = mBusy[i];
        return v;
    endfunction

    // Advance the model across one rising edge using the pre-edge inputs.
    task automatic stepClock();
        logic st;
        st = modelStall();
        if (wb_in.Wreg && wb_in.rd != 0) begin
            mRegs[wb_in.rd] = wb_in.Wdata;
            mBusy[wb_in.rd] = 1'b0;
        end
        if (issue_valid && issue_Wreg && issue_rd != 0 && !st) mBusy[issue_rd] = 1'b1;
        @(posedge Clock);
    endtask

    task automatic applyStimulus(input logic wreg, input reg_idx_t wrd, input xword_t wdata,
                                 input reg_idx_t r1, input reg_idx_t r2, input logic u1, input logic u2,
                                 input logic iv, input logic iw, input reg_idx_t ird);
        @(negedge Clock);
        wb_in        = '0;
        wb_in.Wreg   = wreg;
        wb_in.rd     = wrd;
        wb_in.Wdata  = wdata;
        wb_in.WregR  = ~wreg;
        wb_in.rdR    = ~wrd;
        wb_in.WdataR = ~wdata;
        rs1 = r1;
        rs2 = r2;
        use_rs1 = u1;
        use_rs2 = u2;
        issue_valid = iv;
        issue_Wreg  = iw;
        issue_rd    = ird;
        #1;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_rdata1"}, rdata1, modelRead(rs1));
        checkOutput({tag, "_rdata2"}, rdata2, modelRead(rs2));
        checkOutput({tag, "_stall"}, {31'b0, stall}, {31'b0, modelStall()});
        checkOutput({tag, "_busy"}, busy_vec, modelBusyVec());
    endtask

    initial begin
        logic     wreg, u1, u2, iv, iw;
        reg_idx_t wrd, r1, r2, ird;
        xword_t   wdata;
        int       busyList[$];

        nReset = 1'b1;
        wb_in = '0;
        rs1 = 5'd5;
        rs2 = 5'd31;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        issue_valid = 1'b0;
        issue_Wreg = 1'b0;
        issue_rd = '0;
        modelReset();
        #1 nReset = 1'b0;
        #1;
        checkOutput("t1_rdata1", rdata1, 32'h0);
        checkOutput("t1_rdata2", rdata2, 32'h0);
        checkOutput("t1_stall", {31'b0, stall}, 32'h0);
        checkOutput("t1_busy", busy_vec, 32'h0);
        applyStimulus(1'b1, 5'd5, 32'hCAFEF00D, 5'd5, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("t1_rdata1_wb_in_reset", rdata1, 32'h0);
        @(negedge Clock);
        nReset = 1'b1;

        // Write then read: bypass in the same cycle, array afterwards.
        applyStimulus(1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("t2_bypass", rdata1, 32'hDEADBEEF);
        stepClock();
        applyStimulus(1'b0, 5'd7, 32'h0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("t2_array", rdata1, 32'hDEADBEEF);
        stepClock();

        applyStimulus(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("t3_x0_same", rdata1, 32'h0);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("t3_x0_next", rdata1, 32'h0);
        checkOutput("t3_busy0", {31'b0, busy_vec[0]}, 32'h0);
        stepClock();

        // Load-use stall resolved by a same-cycle write-back.
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        checkOutput("t4_busy3", {31'b0, busy_vec[3]}, 32'h1);
        checkOutput("t4_stall", {31'b0, stall}, 32'h1);
        stepClock();
        applyStimulus(1'b1, 5'd3, 32'hA5A5A5A5, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        checkOutput("t4_stall_resolved", {31'b0, stall}, 32'h0);
        checkOutput("t4_rdata2", rdata2, 32'hA5A5A5A5);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        checkOutput("t4_busy3_clear", {31'b0, busy_vec[3]}, 32'h0);
        stepClock();

        // Simultaneous set and clear of x9: the new writer keeps it busy.
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9);
        stepClock();
        applyStimulus(1'b1, 5'd9, 32'h0BADF00D, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("t5_busy9", {31'b0, busy_vec[9]}, 32'h1);
        checkOutput("t5_reg9", rdata1, 32'h0BADF00D);
        stepClock();

        // Async reset between edges drops pending busy state.
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd12);
        stepClock();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        checkAll("t6_pre");
        checkOutput("t6_busy_pre", busy_vec, 32'h0000_1210);
        nReset = 1'b0;
        modelReset();
        #1;
        checkOutput("t6_busy", busy_vec, 32'h0);
        checkOutput("t6_rdata1", rdata1, 32'h0);
        checkOutput("t6_stall", {31'b0, stall}, 32'h0);
        @(negedge Clock);
        nReset = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd7, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        checkOutput("t6_array_cleared", rdata1, 32'h0);
        checkAll("t6_post");
        stepClock();

        // Randomized traffic against the model; write-backs favour busy registers.
        for (int cyc = 0; cyc < 400; cyc++) begin
            busyList.delete();
            for (int i = 1; i < NREGS_C; i++) if (mBusy[i]) busyList.push_back(i);
            wreg  = ($urandom_range(1, 0) == 1);
            wdata = $urandom;
            if (busyList.size() > 0 && $urandom_range(9, 0) < 7)
                wrd = reg_idx_t'(busyList[$urandom_range(busyList.size() - 1, 0)]);
            else
                wrd = reg_idx_t'($urandom_range(NREGS_C - 1, 0));
            r1  = reg_idx_t'($urandom_range(NREGS_C - 1, 0));
            r2  = reg_idx_t'($urandom_range(NREGS_C - 1, 0));
            u1  = ($urandom_range(1, 0) == 1);
            u2  = ($urandom_range(1, 0) == 1);
            iv  = ($urandom_range(2, 0) != 0);
            iw  = ($urandom_range(3, 0) != 0);
            ird = reg_idx_t'($urandom_range(NREGS_C - 1, 0));
            if (mBusy[ird] && !(wreg && wrd == ird)) iv = 1'b0;
            applyStimulus(wreg, wrd, wdata, r1, r2, u1, u2, iv, iw, ird);
            checkAll("rand");
            stepClock();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
- Architectural register file and hazard scoreboard at the consuming end of the write-back interface.
- Accepts the write-back stage's Wreg/rd/Wdata each cycle, commits it to a 32x32 array, and serves two decode-stage read ports with same-cycle write-through bypass.
- Tracks registers with in-flight writes (busy bits) and raises a stall when decode reads a register whose value is not yet available.

Parameters:
- NREGS, 32, number of architectural registers (x0 hardwired zero).
- XLEN, 32, register data width.
- AW, 5, register index width; must equal clog2(NREGS).

Ports:
- Clock  input  1  system clock, rising-edge.
- nReset  input  1  asynchronous, active-low reset.
- wb_in  input  write_back_out_t  write-back bundle; fields Wreg, rd, Wdata are used, and the registered fields WregR, rdR, WdataR are ignored.
- rs1  input  AW  read port 1 index.
- rs2  input  AW  read port 2 index.
- rdata1  output  XLEN  read port 1 data.
- rdata2  output  XLEN  read port 2 data.
- issue_valid  input  1  decode issues an instruction this cycle.
- issue_Wreg  input  1  the issued instruction writes a register.
- issue_rd  input  AW  destination of the issued instruction.
- use_rs1  input  1  issued/decoding instruction reads rs1.
- use_rs2  input  1  issued/decoding instruction reads rs2.
- stall  output  1  decode must hold; RAW hazard on a busy source.
- busy_vec  output  NREGS  current busy bits, for debug and verification.

Behaviour:
- Reset: the array, busy_vec, rdata1/rdata2 and stall all read 0 immediately on nReset low, independent of Clock. Reset asserted mid-operation discards all pending busy state.
- Write: at posedge, if wb_in.Wreg and wb_in.rd != 0, then reg[rd] <= Wdata. Writes to x0 are ignored; reg[0] always reads 0.
- Read (combinational, zero latency):
  - If rsN == 0, rdataN = 0.
  - Else if wb_in.Wreg and wb_in.rd == rsN, rdataN = wb_in.Wdata (write-through bypass).
  - Else rdataN = reg[rsN].
- Scoreboard set: at posedge, if issue_valid and issue_Wreg and issue_rd != 0 and !stall, then busy[issue_rd] <= 1.
- Scoreboard clear: at posedge, if wb_in.Wreg and wb_in.rd != 0, then busy[wb_in.rd] <= 0.
- Simultaneous set and clear of the same index: set wins. The newer instruction owns the register; the retiring write still updates the array.
- Set and clear of different indices in the same cycle both take effect.
- stall (combinational):
  - Asserted when use_rs1 and rs1 != 0 and busy[rs1] and !(wb_in.Wreg and wb_in.rd == rs1), or the same condition for rs2.
  - A write-back arriving in the same cycle resolves the hazard through the bypass, so no stall.
- Single outstanding writer per register: decode never issues a second writer to a busy rd. The bench checks this with an assertion; the RTL does not queue writers.
- busy[0] is constantly 0.

Decomposition:
- core_types_pkg gains:
  - constants NREGS_C, XLEN_C, AW_C;
  - typedef reg_idx_t = logic [AW_C-1:0];
  - typedef xword_t = logic [XLEN_C-1:0].
  write_back_out_t is reused unchanged.
- One natural sub-module, scoreboard, holding busy bits, set/clear priority and stall logic. The array and bypass stay in the top module.
- Target size is about 150–250 lines total.

Test Plan:
1. Reset then read: nReset low, rs1=5, rs2=31 -> rdata1=rdata2=0, stall=0, busy_vec=0.
2. Write then read:
   - Cycle N: wb_in Wreg=1, rd=7, Wdata=0xDEADBEEF, rs1=7 -> rdata1=0xDEADBEEF in cycle N (bypass).
   - Cycle N+1: Wreg=0 -> rdata1 still 0xDEADBEEF from the array.
3. x0 protection: Wreg=1, rd=0, Wdata=0x12345678, rs1=0 -> rdata1=0 in the same and the next cycle; busy_vec[0]=0.
4. Load-use stall:
   - Issue rd=3 -> busy_vec[3]=1.
   - Next cycle use_rs2=1, rs2=3, no write-back -> stall=1.
   - Write-back rd=3, Wdata=0xA5A5A5A5 -> stall=0 the same cycle, rdata2=0xA5A5A5A5, busy[3] clears at the edge.
5. Simultaneous set/clear: busy[9]=1; in one cycle wb_in writes rd=9 and issue rd=9 -> after the edge busy[9]=1 and reg[9] holds the new Wdata.
6. Async reset mid-flight: busy bits {4, 12} set, nReset pulsed low between clock edges -> busy_vec=0 and rdata=0 immediately, stall=0.
